// File: rtl/hash_update_arbiter_if.sv
// Handshake bundle between the hash-update round-robin arbiter and its
// surroundings: the four request lanes, the registered mux select, the
// valid/ready pair toward the hash-table write stage and the optional
// per-lane grant counters.
//   master : the arbiter side (drives ready pulses, select, valid, stats)
//   slave  : the request lanes plus the downstream write stage
interface hash_update_arbiter_if #(
  parameter int NUM_LANES = 4,
  parameter int SEL_W     = 2,
  parameter int STAT_W    = 32
);
  logic [NUM_LANES-1:0]        req_valid;
  logic [NUM_LANES-1:0]        req_ready;
  logic [SEL_W-1:0]            sel;
  logic                        out_valid;
  logic                        out_ready;
  logic [SEL_W-1:0]            out_lane;
  logic [NUM_LANES*STAT_W-1:0] stat_cnt;

  modport master (
    input  req_valid, out_ready,
    output req_ready, sel, out_valid, out_lane, stat_cnt
  );

  modport slave (
    output req_valid, out_ready,
    input  req_ready, sel, out_valid, out_lane, stat_cnt
  );
endinterface

// File: rtl/hash_update_arbiter.sv
// Round-robin arbiter in front of the 4:1 hash-update data mux.
// A grant is held (sel stable, out_valid high) until the write stage accepts
// the word; the accepted lane gets a one-cycle req_ready pulse and is masked
// from the immediately following arbitration so other lanes go back-to-back.
// Optional per-lane grant counters are built when HASH_UPD_ARB_STATS_EN is
// defined; otherwise stat_cnt is tied to zero.
module hash_update_arbiter #(
  parameter int NUM_LANES = 4,   // fixed at 4: matches the 2-bit mux select
  parameter int SEL_W     = 2,
  parameter int STAT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  hash_update_arbiter_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     last_grant_q, last_grant_d;
  logic [NUM_LANES-1:0] req_ready_c;
  logic                 accept;

  logic [NUM_LANES-1:0] sel_onehot;
  logic                 idle_found, hold_found;
  logic [SEL_W-1:0]     idle_lane, hold_lane;

  // First set bit of req, searching upward from start with wrap-around.
  // Result is {found, lane}.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                             input logic [SEL_W-1:0]     start);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = start + SEL_W'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  assign sel_onehot = NUM_LANES'(1) << sel_q;

  // From IDLE the priority pointer sits just after the last accepted lane.
  assign {idle_found, idle_lane} = rr_pick(bus.req_valid, last_grant_q + 1'b1);

  // On accept the consumed lane is masked: its next word may not be on the
  // mux inputs yet, so it waits one arbitration round.
  assign {hold_found, hold_lane} = rr_pick(bus.req_valid & ~sel_onehot, sel_q + 1'b1);

  // Next-state, select and ready-pulse logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    req_ready_c  = '0;
    accept       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (idle_found) begin
          sel_d   = idle_lane;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Without out_ready the grant is frozen; late higher-priority
        // requests are deliberately ignored to keep the mux output stable.
        if (bus.out_ready) begin
          accept       = 1'b1;
          req_ready_c  = sel_onehot;
          last_grant_d = sel_q;
          if (hold_found) begin
            sel_d = hold_lane;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, select and round-robin pointer registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= SEL_W'(NUM_LANES - 1);  // lane 0 wins first after reset
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.sel       = sel_q;
  assign bus.out_lane  = sel_q;
  assign bus.out_valid = (state_q == HOLD);

`ifdef HASH_UPD_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_LANES];

  // Per-lane accept counters, wrapping naturally at 2^STAT_W.
  always_ff @(posedge clk) begin
    // NOTE: this small array is software-visible state, so unlike a data
    // memory it is cleared by reset.
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        stat_q[i] <= '0;
      end
    end else if (accept) begin
      stat_q[sel_q] <= stat_q[sel_q] + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_stat
    assign bus.stat_cnt[g*STAT_W +: STAT_W] = stat_q[g];
  end
`else
  assign bus.stat_cnt = {(NUM_LANES*STAT_W){1'b0}};
`endif

`ifndef SYNTHESIS
  // Lanes that were valid but not consumed last cycle must still be valid.
  logic [NUM_LANES-1:0] pending_q;

  // Remember which lanes are owed a ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= bus.req_valid & ~req_ready_c;
    end
  end

  a_req_valid_held: assert property (
    @(posedge clk) disable iff (rst) ((pending_q & ~bus.req_valid) == '0)
  );
`endif

endmodule
